// File: rtl/cpu_debug_jtag_scan_master_pkg.sv
// cpu_debug_scan_pkg: shared types and constants for the debug-slave virtual-JTAG scan master
package cpu_debug_scan_pkg;
   localparam int DBG_DR_WIDTH = 38;
   localparam int DBG_IR_WIDTH = 2;
   localparam logic [DBG_IR_WIDTH-1:0] OCIMEM    = 2'd0;
   localparam logic [DBG_IR_WIDTH-1:0] TRACEMEM  = 2'd1;
   localparam logic [DBG_IR_WIDTH-1:0] BREAK     = 2'd2;
   localparam logic [DBG_IR_WIDTH-1:0] TRACECTRL = 2'd3;
   typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, DONE} scan_state_e;
endpackage

// File: rtl/cpu_debug_jtag_scan_master_if.sv
// cpu_debug_jtag_scan_master_if: command/response handshake plus vji scan bus
interface cpu_debug_jtag_scan_master_if
   import cpu_debug_scan_pkg::*;
   #(parameter int DR_WIDTH = DBG_DR_WIDTH, parameter int IR_WIDTH = DBG_IR_WIDTH);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [IR_WIDTH-1:0] cmd_ir;
   logic                cmd_ir_update;
   logic [DR_WIDTH-1:0] cmd_dr;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DR_WIDTH-1:0] rsp_dr;
   logic [IR_WIDTH-1:0] rsp_ir_out;
   logic                vji_tck;
   logic                vji_tdi;
   logic [IR_WIDTH-1:0] vji_ir_in;
   logic                vji_uir;
   logic                vji_cdr;
   logic                vji_sdr;
   logic                vji_udr;
   logic                vji_rti;
   logic                vji_tdo;
   logic [IR_WIDTH-1:0] vji_ir_out;
   modport master (
      input  cmd_valid, cmd_ir, cmd_ir_update, cmd_dr, rsp_ready, vji_tdo, vji_ir_out,
      output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out,
      output vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
   );
   modport slave (
      output cmd_valid, cmd_ir, cmd_ir_update, cmd_dr, rsp_ready, vji_tdo, vji_ir_out,
      input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out,
      input  vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
   );
endinterface

// File: rtl/cpu_debug_jtag_scan_master_tck_gen.sv
// cpu_debug_tck_gen: divides clk into tck with TCK_DIV-cycle low and high phases, flagging rise/fall cycles
module cpu_debug_tck_gen #(
   parameter int TCK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic run_i,
   output logic tck_o,
   output logic rise_pt_o,
   output logic fall_pt_o
);
   localparam int CW = TCK_DIV > 1 ? $clog2(TCK_DIV) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tck_q, term;
   assign term      = run_i && (cnt_q == CW'(TCK_DIV - 1));
   assign cnt_d     = term ? '0 : cnt_q + 1'b1;
   assign rise_pt_o = term & ~tck_q;
   assign fall_pt_o = term & tck_q;
   assign tck_o     = tck_q;
   // phase counter; tck toggles at the end of each half period and parks low when idle
   always_ff @(posedge clk) begin
      if (reset || !run_i) begin
         cnt_q <= '0;
         tck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tck_q <= term ? ~tck_q : tck_q;
      end
   end
endmodule

// File: rtl/cpu_debug_jtag_scan_master.sv
// cpu_debug_jtag_scan_master: drives one optional IR update plus a full DR scan per accepted command
module cpu_debug_jtag_scan_master
   import cpu_debug_scan_pkg::*;
   #(
   parameter int DR_WIDTH = DBG_DR_WIDTH,
   parameter int IR_WIDTH = DBG_IR_WIDTH,
   parameter int TCK_DIV  = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   cpu_debug_jtag_scan_master_if.master  bus
);
   localparam int BW = $clog2(DR_WIDTH + 1);
   scan_state_e         state_q;
   logic [DR_WIDTH-1:0] sr_q;
   logic [BW-1:0]       bit_q;
   logic                tdo_q;
   logic                rsp_valid_q;
   logic [IR_WIDTH-1:0] ir_in_q;
   logic [IR_WIDTH-1:0] ir_out_q;
   logic                run, tck, rise_pt, fall_pt;
   assign run = (state_q != IDLE) && (state_q != DONE);
   cpu_debug_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
      .clk       (clk),
      .reset     (reset),
      .run_i     (run),
      .tck_o     (tck),
      .rise_pt_o (rise_pt),
      .fall_pt_o (fall_pt)
   );
   // scan sequencer: state advances on tck fall points, tdo captured on rise points
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         bit_q       <= '0;
         tdo_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         ir_in_q     <= '0;
         ir_out_q    <= '0;
      end else begin
         if (rise_pt) tdo_q <= bus.vji_tdo;
         if (rise_pt && state_q == CDR) ir_out_q <= bus.vji_ir_out;
         case (state_q)
            IDLE: if (bus.cmd_valid) begin
               sr_q    <= bus.cmd_dr;
               bit_q   <= '0;
               ir_in_q <= bus.cmd_ir_update ? bus.cmd_ir : ir_in_q;
               state_q <= bus.cmd_ir_update ? UIR : CDR;
            end
            UIR: if (fall_pt) state_q <= CDR;
            CDR: if (fall_pt) state_q <= SDR;
            SDR: if (fall_pt) begin
               sr_q    <= {tdo_q, sr_q[DR_WIDTH-1:1]};
               bit_q   <= (bit_q == BW'(DR_WIDTH - 1)) ? '0 : bit_q + 1'b1;
               state_q <= (bit_q == BW'(DR_WIDTH - 1)) ? UDR : SDR;
            end
            UDR: if (fall_pt) state_q <= RTI;
            RTI: if (fall_pt) state_q <= DONE;
            DONE: if (!rsp_valid_q) begin
               rsp_valid_q <= 1'b1;
            end else if (bus.rsp_ready) begin
               rsp_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.cmd_ready  = (state_q == IDLE);
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_dr     = sr_q;
   assign bus.rsp_ir_out = ir_out_q;
   assign bus.vji_tck    = tck;
   assign bus.vji_tdi    = (state_q == SDR) & sr_q[0];
   assign bus.vji_ir_in  = ir_in_q;
   assign bus.vji_uir    = (state_q == UIR);
   assign bus.vji_cdr    = (state_q == CDR);
   assign bus.vji_sdr    = (state_q == SDR);
   assign bus.vji_udr    = (state_q == UDR);
   assign bus.vji_rti    = (state_q == RTI);
endmodule

// File: tb/tb_cpu_debug_jtag_scan_master.sv
// tb_cpu_debug_jtag_scan_master: loopback-slave bench for the scan master at TCK_DIV 2 and 1
module tb_cpu_debug_jtag_scan_master;
   localparam int DW = 38;
   localparam int IW = 2;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   cpu_debug_jtag_scan_master_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) b0 ();
   cpu_debug_jtag_scan_master_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) b1 ();
   cpu_debug_jtag_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(2)) dut0 (.clk(clk), .reset(reset), .bus(b0));
   cpu_debug_jtag_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
   logic          sel = 1'b0;
   logic          cmd_valid, cmd_ir_update, rsp_ready;
   logic [IW-1:0] cmd_ir, ir_out_v;
   logic [DW-1:0] cmd_dr;
   logic [DW-1:0] slave, pre_val;
   int            pre_req = 0, pre_seen = 0;
   assign b0.cmd_valid = cmd_valid & ~sel;
   assign b1.cmd_valid = cmd_valid & sel;
   assign b0.cmd_ir = cmd_ir;               assign b1.cmd_ir = cmd_ir;
   assign b0.cmd_ir_update = cmd_ir_update; assign b1.cmd_ir_update = cmd_ir_update;
   assign b0.cmd_dr = cmd_dr;               assign b1.cmd_dr = cmd_dr;
   assign b0.rsp_ready = rsp_ready;         assign b1.rsp_ready = rsp_ready;
   assign b0.vji_tdo = slave[0];            assign b1.vji_tdo = slave[0];
   assign b0.vji_ir_out = ir_out_v;         assign b1.vji_ir_out = ir_out_v;
   logic          tck, tdi, uir, cdr, sdr, udr, rti, rsp_valid, cmd_ready;
   logic [IW-1:0] ir_in, rsp_ir_out;
   logic [DW-1:0] rsp_dr;
   assign tck        = sel ? b1.vji_tck    : b0.vji_tck;
   assign tdi        = sel ? b1.vji_tdi    : b0.vji_tdi;
   assign uir        = sel ? b1.vji_uir    : b0.vji_uir;
   assign cdr        = sel ? b1.vji_cdr    : b0.vji_cdr;
   assign sdr        = sel ? b1.vji_sdr    : b0.vji_sdr;
   assign udr        = sel ? b1.vji_udr    : b0.vji_udr;
   assign rti        = sel ? b1.vji_rti    : b0.vji_rti;
   assign ir_in      = sel ? b1.vji_ir_in  : b0.vji_ir_in;
   assign rsp_valid  = sel ? b1.rsp_valid  : b0.rsp_valid;
   assign cmd_ready  = sel ? b1.cmd_ready  : b0.cmd_ready;
   assign rsp_ir_out = sel ? b1.rsp_ir_out : b0.rsp_ir_out;
   assign rsp_dr     = sel ? b1.rsp_dr     : b0.rsp_dr;
   logic          tck_prev = 1'b0;
   logic [IW-1:0] uir_ir = '0;
   int            tck_edges = 0, sdr_rises = 0, uir_rises = 0, viol = 0;
   // loopback debug slave: shifts tdi in on tck rise during SDR, tdo is the register LSB
   always @(negedge clk) begin
      tck_prev <= tck;
      if (tck != tck_prev) tck_edges <= tck_edges + 1;
      if ($countones({uir, cdr, sdr, udr, rti}) > 1 || (tck && !(uir | cdr | sdr | udr | rti)) || (tdi && !sdr))
         viol <= viol + 1;
      if (pre_req != pre_seen) begin
         slave    <= pre_val;
         pre_seen <= pre_req;
      end else if (tck && !tck_prev) begin
         if (sdr) begin
            slave     <= {tdi, slave[DW-1:1]};
            sdr_rises <= sdr_rises + 1;
         end
         if (uir) begin
            uir_rises <= uir_rises + 1;
            uir_ir    <= ir_in;
         end
      end
   end
   int            tests = 0, fails = 0;
   int            s0, u0;
   logic [DW-1:0] model_slave, exp_dr;
   logic [IW-1:0] exp_irout;
   logic [IW-1:0] cur_ir [2];
   logic          exp_upd;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic start(input logic [IW-1:0] ir, input logic upd, input logic [DW-1:0] dr,
                        input logic [IW-1:0] irout, input logic do_pre, input logic [DW-1:0] pre);
      int w;
      if (do_pre) begin
         pre_val = pre;
         pre_req++;
         model_slave = pre;
      end
      exp_dr = model_slave;
      model_slave = dr;
      exp_upd = upd;
      exp_irout = irout;
      if (upd) cur_ir[sel] = ir;
      @(negedge clk);
      ir_out_v = irout;
      cmd_ir = ir;
      cmd_ir_update = upd;
      cmd_dr = dr;
      cmd_valid = 1'b1;
      w = 0;
      while (!cmd_ready && w < 1000) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      s0 = sdr_rises;
      u0 = uir_rises;
   endtask
   task automatic check_rsp(input string tag);
      int n, div;
      div = sel ? 1 : 2;
      n = 0;
      do begin
         @(posedge clk);
         #1 n++;
      end while (!rsp_valid && n < 2000);
      chk({tag, "_latency"}, n, (DW + 3 + int'(exp_upd)) * 2 * div + 1);
      chk({tag, "_rsp_dr"}, rsp_dr, exp_dr);
      chk({tag, "_rsp_ir_out"}, rsp_ir_out, exp_irout);
      chk({tag, "_sdr_pulses"}, sdr_rises - s0, DW);
      chk({tag, "_uir_pulses"}, uir_rises - u0, exp_upd);
      if (exp_upd) chk({tag, "_uir_ir"}, uir_ir, cur_ir[sel]);
      chk({tag, "_ir_in"}, ir_in, cur_ir[sel]);
      chk({tag, "_slave"}, slave, model_slave);
      chk({tag, "_busy"}, cmd_ready, 1'b0);
   endtask
   task automatic finish_rsp(input string tag);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 chk({tag, "_rsp_drop"}, rsp_valid, 1'b0);
      chk({tag, "_idle"}, cmd_ready, 1'b1);
      rsp_ready = 1'b0;
   endtask
   initial begin
      int e0, bad, w;
      logic [DW-1:0] snap;
      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_ir = '0;
      cmd_ir_update = 1'b0;
      cmd_dr = '0;
      rsp_ready = 1'b0;
      ir_out_v = '0;
      cur_ir[0] = '0;
      cur_ir[1] = '0;
      model_slave = '0;
      repeat (3) @(posedge clk);
      #1 chk("rst_vji", {tck, tdi, uir, cdr, sdr, udr, rti, ir_in, rsp_valid}, '0);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_rsp_dr", rsp_dr, '0);
      chk("rst_rsp_ir_out", rsp_ir_out, '0);
      @(negedge clk);
      reset = 1'b0;
      e0 = tck_edges;
      repeat (50) @(posedge clk);
      #1 chk("idle_tck_quiet", tck_edges - e0, 0);
      start(2'b01, 1'b1, 38'h2A_5555_AAAA, 2'b10, 1'b1, 38'h12_3456_789A);
      check_rsp("ir_upd");
      finish_rsp("ir_upd");
      rsp_ready = 1'b1;
      start(2'b11, 1'b0, 38'h2A_5555_AAAA, 2'b01, 1'b0, '0);
      check_rsp("no_upd");
      finish_rsp("no_upd");
      for (int i = 0; i < 3; i++) begin
         start(IW'($urandom), 1'($urandom), {6'($urandom), 32'($urandom)}, IW'($urandom),
               1'($urandom), {6'($urandom), 32'($urandom)});
         check_rsp("rand");
         finish_rsp("rand");
      end
      start(2'b10, 1'b1, {6'($urandom), 32'($urandom)}, 2'b11, 1'b1, {6'($urandom), 32'($urandom)});
      check_rsp("hold_a");
      @(negedge clk);
      exp_dr = model_slave;
      model_slave = {6'($urandom), 32'($urandom)};
      exp_upd = 1'b0;
      exp_irout = 2'b01;
      ir_out_v = 2'b01;
      cmd_dr = model_slave;
      cmd_ir = 2'b00;
      cmd_ir_update = 1'b0;
      cmd_valid = 1'b1;
      snap = rsp_dr;
      bad = 0;
      repeat (20) begin
         @(posedge clk);
         #1 if (rsp_dr !== snap || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) bad++;
      end
      chk("hold_stable", bad, 0);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 chk("hold_release_idle", cmd_ready, 1'b1);
      chk("hold_release_drop", rsp_valid, 1'b0);
      rsp_ready = 1'b0;
      @(posedge clk);
      #1 chk("pending_accepted", cmd_ready, 1'b0);
      cmd_valid = 1'b0;
      s0 = sdr_rises;
      u0 = uir_rises;
      check_rsp("pending");
      finish_rsp("pending");
      start(2'b01, 1'b1, {6'($urandom), 32'($urandom)}, 2'b10, 1'b1, {6'($urandom), 32'($urandom)});
      w = 0;
      while (sdr_rises - s0 < 10 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      chk("mid_sdr_reached", w < 1000, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1 chk("mid_rst_vji", {tck, tdi, uir, cdr, sdr, udr, rti, ir_in, rsp_valid}, '0);
      chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
      chk("mid_rst_rsp", {rsp_dr, rsp_ir_out}, '0);
      cur_ir[0] = '0;
      cur_ir[1] = '0;
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      repeat (200) begin
         @(posedge clk);
         #1 if (rsp_valid !== 1'b0) bad++;
      end
      chk("mid_rst_no_rsp", bad, 0);
      start(2'b11, 1'b0, {6'($urandom), 32'($urandom)}, 2'b11, 1'b1, {6'($urandom), 32'($urandom)});
      check_rsp("after_rst");
      finish_rsp("after_rst");
      @(negedge clk);
      sel = 1'b1;
      start(2'b10, 1'b1, {6'($urandom), 32'($urandom)}, 2'b01, 1'b1, {6'($urandom), 32'($urandom)});
      check_rsp("div1_a");
      finish_rsp("div1_a");
      start(2'b01, 1'b0, {6'($urandom), 32'($urandom)}, 2'b10, 1'b0, '0);
      check_rsp("div1_b");
      finish_rsp("div1_b");
      repeat (2) @(posedge clk);
      #1 chk("strobe_rules", viol, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
